// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch/execute sequencer that drives datapath strobes from the current
// state and the opcode field of IR.
module control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        PCin,
  output logic        Yin,
  output logic        Zin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic [3:0]  step
);

  typedef enum logic [3:0] {
    StRst  = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT2   = 4'd3,
    StT3   = 4'd4,
    StT4   = 4'd5,
    StT5   = 4'd6,
    StT6   = 4'd7,
    StT7   = 4'd8,
    StHalt = 4'd15
  } state_e;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpHalt = 5'b11011;

  state_e     state_q, state_d;
  logic [4:0] opcode;
  logic       is_rtype, is_imm, is_ld, is_st, is_exec;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  assign is_rtype = (opcode == OpAdd) || (opcode == OpSub) || (opcode == OpAnd) ||
                    (opcode == OpOr);
  assign is_imm   = (opcode == OpAddi) || (opcode == OpLdi);
  assign is_ld    = (opcode == OpLd);
  assign is_st    = (opcode == OpSt);
  assign is_exec  = is_rtype || is_imm || is_ld || is_st;

  always_ff @(posedge clock) begin
    if (reset) state_q <= StRst;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:  state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   state_d = mem_ready ? StT2 : StT1;
      StT2: begin
        if (is_exec)               state_d = StT3;
        else if (opcode == OpHalt) state_d = StHalt;
        else                       state_d = StT0;
      end
      StT3:   state_d = StT4;
      StT4:   state_d = StT5;
      StT5:   state_d = (is_ld || is_st) ? StT6 : StT0;
      StT6: begin
        if (is_ld)      state_d = mem_ready ? StT7 : StT6;
        else if (is_st) state_d = StT7;
        else            state_d = StT0;
      end
      StT7:   state_d = (is_st && !mem_ready) ? StT7 : StT0;
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    Cout    = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    PCin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    alu_op  = 5'b00000;
    run     = (state_q != StRst) && (state_q != StHalt);
    step    = state_q;
    unique case (state_q)
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      StT1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        // Load PC only once, on the completing cycle of the fetch read.
        PCin    = mem_ready;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        Grb = 1'b1;
        Yin = 1'b1;
        // ldi/ld/st use base-address semantics so R0 reads as zero.
        if (is_ld || is_st || opcode == OpLdi) BAout = 1'b1;
        else                                   Rout  = 1'b1;
      end
      StT4: begin
        Zin = 1'b1;
        if (is_rtype) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          alu_op = opcode;
        end else begin
          Cout   = 1'b1;
          alu_op = OpAdd;
        end
      end
      StT5: begin
        Zlowout = 1'b1;
        if (is_ld || is_st) begin
          MARin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      StT6: begin
        if (is_ld) begin
          Read  = 1'b1;
          MDRin = 1'b1;
        end else if (is_st) begin
          Gra   = 1'b1;
          Rout  = 1'b1;
          MDRin = 1'b1;
        end
      end
      StT7: begin
        if (is_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
